jk_excite_drv: RTL and testbench

Synthesizable driver for the `jk_ff` flip-flop.
- Accepts a stream of target bits over a valid/ready handshake.
- Computes the J/K excitation needed to move the flip-flop from its current state to each target, and drives `j`/`k` for exactly one clock.
- Reads back `q` and flags any cycle where the flip-flop did not land on the target.
- Replaces hand-written `#delay` stimulus with a clocked, self-checking source.

---
 rtl/jk_excite_drv.sv | 102 ++++++++++
 tb/tb_jk_excite_drv.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/jk_excite_drv.sv
// Clocked J/K excitation driver and checker for a downstream jk_ff; build with JK_TOGGLE_EN for toggle encoding.
// Latency: j/k from accept edge E0 to E1, check result (chk_done) from E2; in_ready low E0..E2, one target per 3 cycles.
module jk_excite_drv #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             j,
  output logic             k,
  input  logic             q_fb,
  output logic             chk_done,
  output logic             chk_err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             clr_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t     state;
  logic       tgt;
  logic [1:0] exc;
  logic       mismatch;
  logic       cnt_sat;

  // Excitation from the current flip-flop state to the offered target.
  always_comb begin
    exc = 2'b00;
    if (q_fb != in_bit) begin
`ifdef JK_TOGGLE_EN
      exc = 2'b11;
`else
      exc = in_bit ? 2'b10 : 2'b01;
`endif
    end
  end

  assign mismatch = (q_fb != tgt);
  assign cnt_sat  = &err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tgt        <= 1'b0;
      in_ready   <= 1'b1;
      j          <= 1'b0;
      k          <= 1'b0;
      chk_done   <= 1'b0;
      chk_err    <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else begin
      chk_done <= 1'b0;
      chk_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            tgt      <= in_bit;
            j        <= exc[1];
            k        <= exc[0];
            in_ready <= 1'b0;
            state    <= DRIVE;
          end
        end
        DRIVE: begin
          j     <= 1'b0;
          k     <= 1'b0;
          state <= CHECK;
        end
        CHECK: begin
          chk_done <= 1'b1;
          chk_err  <= mismatch;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          j        <= 1'b0;
          k        <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase

      // A clear on the same edge as a recorded mismatch wins.
      if (clr_err) begin
        err_sticky <= 1'b0;
        err_cnt    <= '0;
      end else if (state == CHECK && mismatch) begin
        err_sticky <= 1'b1;
        if (!cnt_sat) err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_jk_excite_drv.sv
// Directed bench for jk_excite_drv with a behavioural jk_ff on the feedback path.
module tb_jk_excite_drv;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       clr_err = 1'b0;
  logic       force0 = 1'b0;
  logic       in_ready, j, k, chk_done, chk_err, err_sticky;
  logic [7:0] err_cnt;
  logic       q_fb, ff_q;
  logic       s_ready, s_j, s_k, s_done, s_err, s_sticky;
  logic [1:0] s_cnt;

  int checks = 0;
  int errors = 0;

`ifdef JK_TOGGLE_EN
  localparam logic [1:0] SET = 2'b11;
  localparam logic [1:0] RST = 2'b11;
`else
  localparam logic [1:0] SET = 2'b10;
  localparam logic [1:0] RST = 2'b01;
`endif
  localparam logic [1:0] HLD = 2'b00;

  always #5 clk = ~clk;

  jk_excite_drv dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .j(j), .k(k), .q_fb(q_fb), .chk_done(chk_done), .chk_err(chk_err),
    .err_sticky(err_sticky), .err_cnt(err_cnt), .clr_err(clr_err)
  );

  jk_excite_drv #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .in_ready(s_ready),
    .j(s_j), .k(s_k), .q_fb(1'b0), .chk_done(s_done), .chk_err(s_err),
    .err_sticky(s_sticky), .err_cnt(s_cnt), .clr_err(clr_err)
  );

  // Behavioural jk_ff on the same clock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff_q <= 1'b0;
    else begin
      case ({j, k})
        2'b10:   ff_q <= 1'b1;
        2'b01:   ff_q <= 1'b0;
        2'b11:   ff_q <= ~ff_q;
        default: ff_q <= ff_q;
      endcase
    end
  end

  assign q_fb = force0 ? 1'b0 : ff_q;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One complete transaction; exp_sat < 0 skips the saturating-counter check.
  task automatic send(input logic b, input logic [1:0] exp_jk, input logic exp_err,
                      input logic clr_at_check, input int exp_sat);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_before_accept got=%b want=1", in_ready); end
    in_valid = 1'b1; in_bit = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if ({j, k} !== exp_jk) begin errors++; $display("FAIL jk_drive tgt=%b got=%b want=%b", b, {j, k}, exp_jk); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL ready_in_drive got=%b want=0", in_ready); end
    @(negedge clk);
    if (clr_at_check) clr_err = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({j, k, chk_done} !== 3'b000) begin errors++; $display("FAIL jk_release got=%b want=000", {j, k, chk_done}); end
    @(posedge clk); #1;
    clr_err = 1'b0;
    checks++;
    if ({chk_done, chk_err} !== {1'b1, exp_err}) begin
      errors++; $display("FAIL chk_pulse got=%b want=%b", {chk_done, chk_err}, {1'b1, exp_err});
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_check got=%b want=1", in_ready); end
    if (exp_sat >= 0) begin
      checks++;
      if (int'(s_cnt) !== exp_sat) begin errors++; $display("FAIL sat_cnt got=%0d want=%0d", s_cnt, exp_sat); end
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({in_ready, j, k, chk_done, chk_err, err_sticky} !== 6'b100000) begin
      errors++; $display("FAIL reset_outputs got=%b want=100000", {in_ready, j, k, chk_done, chk_err, err_sticky});
    end
    checks++;
    if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d want=0", err_cnt); end
  endtask

  task automatic test_stream();
    logic       bits [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0] exps [5] = '{SET, HLD, RST, HLD, SET};
    do_reset();
    for (int i = 0; i < 5; i++) send(bits[i], exps[i], 1'b0, 1'b0, -1);
    checks++;
    if ({err_sticky, err_cnt} !== 9'd0) begin
      errors++; $display("FAIL stream_no_err sticky=%b cnt=%0d want 0/0", err_sticky, err_cnt);
    end
  endtask

  task automatic test_mismatch();
    do_reset();
    force0 = 1'b1;
    for (int i = 0; i < 3; i++) send(1'b1, SET, 1'b1, 1'b0, -1);
    checks++;
    if ({err_sticky, err_cnt} !== {1'b1, 8'd3}) begin
      errors++; $display("FAIL mismatch_count sticky=%b cnt=%0d want 1/3", err_sticky, err_cnt);
    end
    @(negedge clk); clr_err = 1'b1;
    @(posedge clk); #1; clr_err = 1'b0;
    checks++;
    if ({err_sticky, err_cnt} !== 9'd0) begin
      errors++; $display("FAIL clr_err sticky=%b cnt=%0d want 0/0", err_sticky, err_cnt);
    end
    // Clear coinciding with a mismatch edge: chk_err pulses but nothing is recorded.
    send(1'b1, SET, 1'b1, 1'b1, -1);
    checks++;
    if ({err_sticky, err_cnt} !== 9'd0) begin
      errors++; $display("FAIL clr_wins sticky=%b cnt=%0d want 0/0", err_sticky, err_cnt);
    end
    force0 = 1'b0;
  endtask

  task automatic test_saturate();
    int want [6] = '{1, 2, 3, 3, 3, 3};
    do_reset();
    send(1'b1, SET, 1'b0, 1'b0, want[0]);
    for (int i = 1; i < 6; i++) send(1'b1, HLD, 1'b0, 1'b0, want[i]);
    checks++;
    if (s_sticky !== 1'b1) begin errors++; $display("FAIL sat_sticky got=%b want=1", s_sticky); end
  endtask

  task automatic test_back_to_back();
    int done_cnt = 0;
    int accepted = 0;
    logic [1:0] exp_jk;
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_bit = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (in_ready !== (c % 3 == 0)) begin
        errors++; $display("FAIL b2b_ready cyc=%0d got=%b want=%b", c, in_ready, (c % 3 == 0));
      end
      @(posedge clk); #1;
      if (c % 3 == 0) begin
        exp_jk = in_bit ? SET : RST;
        checks++;
        if ({j, k} !== exp_jk) begin errors++; $display("FAIL b2b_jk cyc=%0d got=%b want=%b", c, {j, k}, exp_jk); end
        accepted++;
        in_bit = ~in_bit;
      end else begin
        checks++;
        if ({j, k} !== 2'b00) begin errors++; $display("FAIL b2b_jk_idle cyc=%0d got=%b want=00", c, {j, k}); end
      end
      checks++;
      if ({chk_done, chk_err} !== {(c % 3 == 2), 1'b0}) begin
        errors++; $display("FAIL b2b_done cyc=%0d got=%b want=%b0", c, {chk_done, chk_err}, (c % 3 == 2));
      end
      if (chk_done) begin
        done_cnt++;
        checks++;
        if (ff_q !== ~in_bit) begin errors++; $display("FAIL b2b_ffq cyc=%0d got=%b want=%b", c, ff_q, ~in_bit); end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (done_cnt !== 4 || accepted !== 4) begin
      errors++; $display("FAIL b2b_count done=%0d acc=%0d want 4/4", done_cnt, accepted);
    end
  endtask

  task automatic test_reset_mid();
    logic seen_done = 1'b0;
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_bit = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if ({j, k} !== SET) begin errors++; $display("FAIL mid_accept got=%b want=%b", {j, k}, SET); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({j, k} !== 2'b00) begin errors++; $display("FAIL mid_jk_clear got=%b want=00", {j, k}); end
    @(posedge clk); #1;
    seen_done = seen_done | chk_done;
    @(negedge clk); rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got=%b want=1", in_ready); end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      seen_done = seen_done | chk_done;
    end
    checks++;
    if (seen_done !== 1'b0) begin errors++; $display("FAIL mid_no_done got=%b want=0", seen_done); end
    send(1'b1, SET, 1'b0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_mismatch();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
